i2c_cmd_seq: RTL and testbench

Host-side command sequencer that sits directly upstream of the I2C FIFO IP on its system bus. It takes one I2C transfer request at a time, either a write of 1–16 bytes or a read of 1–16 bytes, through a valid/ready handshake. It drives the IP's strobe/ack register bus and its FIFO status flags to push TX words, issue the command and drain RX data. Returned bytes are streamed out and completion or timeout is flagged.

---
 rtl/i2c_cmd_seq.sv | 267 ++++++++++++++++++++++++++
 tb/tb_i2c_cmd_seq.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_cmd_seq.sv
// i2c_cmd_seq
// Host-side command sequencer for the I2C FIFO IP. Accepts one read or
// write request (1-16 bytes) over a valid/ready handshake, pushes the
// address word and write bytes into the IP TX FIFO, writes the command
// register, then drains read bytes from the RX FIFO. Every wait is guarded
// by a watchdog; on expiry the transfer ends with done_o and err_o together.
//
// Ports
//   clk_i, rst_i                 clock, synchronous active-high reset
//   cmd_valid_i/cmd_ready_o      request handshake (rw, 7-bit addr, len-1)
//   wr_data_i/wr_valid_i/wr_ready_o   write byte stream
//   rd_data_o/rd_valid_o         read byte stream (one-cycle pulse per byte)
//   done_o, err_o                end-of-transfer pulse, error qualifier
//   sb_*                         strobe/ack register bus towards the IP
//   txfifo_f, rxfifo_e, mrdcmpl  IP FIFO status flags
module i2c_cmd_seq #(
    parameter int            AW       = 4,
    parameter int            DW       = 10,
    parameter logic [AW-1:0] ADR_TXDR = 4'h8,
    parameter logic [AW-1:0] ADR_RXDR = 4'h9,
    parameter logic [AW-1:0] ADR_CMDR = 4'h7,
    parameter int            TO_CYC   = 4095
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          cmd_valid_i,
    output logic          cmd_ready_o,
    input  logic          cmd_rw_i,
    input  logic [6:0]    cmd_addr_i,
    input  logic [3:0]    cmd_len_i,
    input  logic [7:0]    wr_data_i,
    input  logic          wr_valid_i,
    output logic          wr_ready_o,
    output logic [7:0]    rd_data_o,
    output logic          rd_valid_o,
    output logic          done_o,
    output logic          err_o,
    output logic          sb_stb_o,
    output logic          sb_cs_o,
    output logic          sb_we_o,
    output logic [AW-1:0] sb_adr_o,
    output logic [DW-1:0] sb_dat_o,
    input  logic [DW-1:0] sb_dat_i,
    input  logic          sb_ack_i,
    input  logic          txfifo_f,
    input  logic          rxfifo_e,
    input  logic          mrdcmpl
);

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_WDATA, S_CMD, S_RWAIT, S_RDATA, S_DONE
    } state_t;

    localparam logic [11:0] TO_LIM = 12'(TO_CYC);

    state_t          state_q, state_d;
    logic            rw_q, rw_d;
    logic [6:0]      addr_q, addr_d;
    logic [3:0]      len_q, len_d;
    logic [4:0]      cnt_q, cnt_d;
    logic [11:0]     wd_q, wd_d;
    logic            stb_q, stb_d;
    logic            we_q, we_d;
    logic [AW-1:0]   adr_q, adr_d;
    logic [DW-1:0]   dat_q, dat_d;
    logic            cmd_ready_q, cmd_ready_d;
    logic            wr_ready_q, wr_ready_d;
    logic [7:0]      rd_data_q, rd_data_d;
    logic            rd_valid_q, rd_valid_d;
    logic            done_q, done_d;
    logic            err_q, err_d;

    logic            ack;
    logic            busy;
    logic [4:0]      total;
    logic [4:0]      cnt_inc;
    logic            last_byte;
    logic            unused_dat;

    // An ack only counts while a bus cycle is open; a stray ack is ignored.
    assign ack        = stb_q & sb_ack_i;
    assign busy       = (state_q != S_IDLE) && (state_q != S_DONE);
    assign total      = {1'b0, len_q} + 5'd1;
    assign cnt_inc    = cnt_q + 5'd1;
    assign last_byte  = (cnt_q == {1'b0, len_q});
    assign unused_dat = &{1'b0, sb_dat_i[DW-1:8]};

    always_comb begin
        state_d     = state_q;
        rw_d        = rw_q;
        addr_d      = addr_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        stb_d       = stb_q;
        we_d        = we_q;
        adr_d       = adr_q;
        dat_d       = dat_q;
        cmd_ready_d = cmd_ready_q;
        rd_data_d   = rd_data_q;
        wr_ready_d  = 1'b0;
        rd_valid_d  = 1'b0;
        done_d      = 1'b0;
        err_d       = 1'b0;
        wd_d        = wd_q;

        if (ack) begin
            stb_d = 1'b0;
            we_d  = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (cmd_valid_i && cmd_ready_q) begin
                    rw_d        = cmd_rw_i;
                    addr_d      = cmd_addr_i;
                    len_d       = cmd_len_i;
                    cnt_d       = 5'd0;
                    cmd_ready_d = 1'b0;
                    state_d     = S_ADDR;
                end
            end
            S_ADDR: begin
                if (ack) begin
                    state_d = rw_q ? S_CMD : S_WDATA;
                end else if (!stb_q && !txfifo_f) begin
                    stb_d = 1'b1;
                    we_d  = 1'b1;
                    adr_d = ADR_TXDR;
                    dat_d = {2'b01, addr_q, rw_q};
                end
            end
            S_WDATA: begin
                if (ack) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == total) begin
                        state_d = S_CMD;
                    end
                end else if (!stb_q && wr_valid_i && !txfifo_f) begin
                    // Byte is latched straight into the bus data register;
                    // the ready pulse tells upstream to advance.
                    wr_ready_d = 1'b1;
                    stb_d      = 1'b1;
                    we_d       = 1'b1;
                    adr_d      = ADR_TXDR;
                    dat_d      = {last_byte, 1'b0, wr_data_i};
                end
            end
            S_CMD: begin
                if (ack) begin
                    if (rw_q) begin
                        state_d = S_RWAIT;
                    end else begin
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end
                end else if (!stb_q) begin
                    stb_d = 1'b1;
                    we_d  = 1'b1;
                    adr_d = ADR_CMDR;
                    dat_d = {rw_q, 1'b1, 4'b0000, len_q};
                end
            end
            S_RWAIT: begin
                if (!rxfifo_e) begin
                    stb_d   = 1'b1;
                    we_d    = 1'b0;
                    adr_d   = ADR_RXDR;
                    state_d = S_RDATA;
                end else if (mrdcmpl) begin
                    // Master finished but the FIFO ran dry early.
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_RDATA: begin
                if (ack) begin
                    rd_data_d  = sb_dat_i[7:0];
                    rd_valid_d = 1'b1;
                    cnt_d      = cnt_inc;
                    if (cnt_inc == total) begin
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_RWAIT;
                    end
                end
            end
            S_DONE: begin
                cmd_ready_d = 1'b1;
                state_d     = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Watchdog restarts on any progress: state change, ack or a new bus cycle.
        if (!busy || (state_d != state_q) || ack || (stb_d && !stb_q)) begin
            wd_d = 12'd0;
        end else begin
            wd_d = wd_q + 12'd1;
        end

        // Expiry loses to a same-cycle ack, which already took the success path.
        if (busy && !ack && (wd_q == TO_LIM)) begin
            stb_d      = 1'b0;
            we_d       = 1'b0;
            wr_ready_d = 1'b0;
            done_d     = 1'b1;
            err_d      = 1'b1;
            state_d    = S_DONE;
            wd_d       = 12'd0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            rw_q        <= 1'b0;
            addr_q      <= '0;
            len_q       <= '0;
            cnt_q       <= '0;
            wd_q        <= '0;
            stb_q       <= 1'b0;
            we_q        <= 1'b0;
            adr_q       <= '0;
            dat_q       <= '0;
            cmd_ready_q <= 1'b1;
            wr_ready_q  <= 1'b0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            rw_q        <= rw_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            wd_q        <= wd_d;
            stb_q       <= stb_d;
            we_q        <= we_d;
            adr_q       <= adr_d;
            dat_q       <= dat_d;
            cmd_ready_q <= cmd_ready_d;
            wr_ready_q  <= wr_ready_d;
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_valid_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign cmd_ready_o = cmd_ready_q;
    assign wr_ready_o  = wr_ready_q;
    assign rd_data_o   = rd_data_q;
    assign rd_valid_o  = rd_valid_q;
    assign done_o      = done_q;
    assign err_o       = err_q;
    assign sb_stb_o    = stb_q;
    assign sb_cs_o     = stb_q;
    assign sb_we_o     = we_q;
    assign sb_adr_o    = adr_q;
    assign sb_dat_o    = dat_q;

endmodule

// File: tb/tb_i2c_cmd_seq.sv
// Self-checking bench for i2c_cmd_seq: bus/FIFO model with scoreboard queues
// for expected bus writes, read bytes and end-of-transfer status.
module tb_i2c_cmd_seq;

    localparam int TO_CYC = 4095;

    logic       clk = 1'b0;
    logic       rst_i = 1'b1;
    logic       cmd_valid_i = 1'b0;
    logic       cmd_ready_o;
    logic       cmd_rw_i = 1'b0;
    logic [6:0] cmd_addr_i = '0;
    logic [3:0] cmd_len_i = '0;
    logic [7:0] wr_data_i = '0;
    logic       wr_valid_i = 1'b0;
    logic       wr_ready_o;
    logic [7:0] rd_data_o;
    logic       rd_valid_o;
    logic       done_o;
    logic       err_o;
    logic       sb_stb_o, sb_cs_o, sb_we_o;
    logic [3:0] sb_adr_o;
    logic [9:0] sb_dat_o;
    logic [9:0] sb_dat_i = '0;
    logic       sb_ack_i = 1'b0;
    logic       txfifo_f = 1'b0;
    logic       rxfifo_e = 1'b1;
    logic       mrdcmpl = 1'b0;

    int checks = 0;
    int failures = 0;
    int done_cnt = 0;
    int rdv_cnt = 0;
    int wrr_cnt = 0;

    logic [13:0] exp_wr[$];
    logic [7:0]  exp_rd[$];
    logic        exp_done[$];
    logic [7:0]  wr_src[$];
    logic [7:0]  rx_q[$];

    logic block_cmdr = 1'b0;
    logic block_rd = 1'b0;
    logic stray_ack = 1'b0;
    logic rx_tog_en = 1'b0;
    logic rx_tog = 1'b0;

    logic [13:0] mon_wr;
    logic [8:0]  mon_rd;
    logic [1:0]  mon_dn;

    i2c_cmd_seq dut (
        .clk_i(clk), .rst_i(rst_i),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
        .cmd_rw_i(cmd_rw_i), .cmd_addr_i(cmd_addr_i), .cmd_len_i(cmd_len_i),
        .wr_data_i(wr_data_i), .wr_valid_i(wr_valid_i), .wr_ready_o(wr_ready_o),
        .rd_data_o(rd_data_o), .rd_valid_o(rd_valid_o),
        .done_o(done_o), .err_o(err_o),
        .sb_stb_o(sb_stb_o), .sb_cs_o(sb_cs_o), .sb_we_o(sb_we_o),
        .sb_adr_o(sb_adr_o), .sb_dat_o(sb_dat_o), .sb_dat_i(sb_dat_i),
        .sb_ack_i(sb_ack_i),
        .txfifo_f(txfifo_f), .rxfifo_e(rxfifo_e), .mrdcmpl(mrdcmpl)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Bus and RX FIFO model: acks one cycle after strobe, pops RX bytes on reads.
    always @(posedge clk) begin
        if (sb_stb_o && !sb_ack_i && !(block_cmdr && sb_adr_o == 4'h7) &&
            !(block_rd && !sb_we_o)) begin
            sb_ack_i <= 1'b1;
            if (!sb_we_o && rx_q.size() > 0) sb_dat_i <= {2'b00, rx_q.pop_front()};
        end else begin
            sb_ack_i <= stray_ack;
        end
        rx_tog   <= rx_tog_en ? ~rx_tog : 1'b0;
        rxfifo_e <= (rx_q.size() == 0) || rx_tog;
    end

    // Upstream write byte source.
    always @(posedge clk) begin
        if (wr_valid_i && wr_ready_o) void'(wr_src.pop_front());
        wr_valid_i <= (wr_src.size() > 0);
        wr_data_i  <= (wr_src.size() > 0) ? wr_src[0] : 8'h00;
    end

    // Output monitors against the scoreboard.
    always @(negedge clk) begin
        if (sb_stb_o && sb_ack_i && sb_we_o) begin
            mon_wr = (exp_wr.size() > 0) ? exp_wr.pop_front() : 14'h3fff;
            chk("bus_write", 32'({sb_adr_o, sb_dat_o}), 32'(mon_wr));
        end
        if (rd_valid_o) begin
            rdv_cnt++;
            mon_rd = (exp_rd.size() > 0) ? {1'b0, exp_rd.pop_front()} : 9'h100;
            chk("rd_byte", 32'({1'b0, rd_data_o}), 32'(mon_rd));
        end
        if (done_o) begin
            done_cnt++;
            mon_dn = (exp_done.size() > 0) ? {1'b0, exp_done.pop_front()} : 2'b10;
            chk("done_err", 32'({1'b0, err_o}), 32'(mon_dn));
        end else if (err_o) begin
            chk("err_without_done", 32'(done_o), 32'd1);
        end
        if (wr_ready_o) wrr_cnt++;
    end

    task automatic request(input logic rw, input logic [6:0] a, input logic [3:0] l);
        int n;
        n = 0;
        @(negedge clk);
        cmd_rw_i = rw; cmd_addr_i = a; cmd_len_i = l; cmd_valid_i = 1'b1;
        while (!cmd_ready_o && n < 50) begin @(negedge clk); n++; end
        @(negedge clk);
        cmd_valid_i = 1'b0;
        chk("ready_drop_busy", 32'(cmd_ready_o), 32'd0);
    endtask

    task automatic wait_done(input int max, output int n);
        int start;
        start = done_cnt;
        n = 0;
        while (done_cnt == start && n < max) begin @(posedge clk); n++; end
        chk("done_seen", 32'(done_cnt - start), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout observed=hang expected=finish");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int n, rises, d0, r0;
        logic prev;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_cmd_ready", 32'(cmd_ready_o), 32'd1);
        chk("rst_stb", 32'({sb_stb_o, sb_cs_o, sb_we_o}), 32'd0);
        chk("rst_adr_dat", 32'({sb_adr_o, sb_dat_o}), 32'd0);
        chk("rst_pulses", 32'({done_o, err_o, rd_valid_o, wr_ready_o}), 32'd0);
        chk("rst_rd_data", 32'(rd_data_o), 32'd0);
        rst_i = 1'b0;
        @(negedge clk);
        chk("idle_cmd_ready", 32'(cmd_ready_o), 32'd1);

        // Write 2 bytes to 0x50
        wr_src.push_back(8'hA5); wr_src.push_back(8'h3C);
        exp_wr.push_back({4'h8, 10'h1A0}); exp_wr.push_back({4'h8, 10'h0A5});
        exp_wr.push_back({4'h8, 10'h23C}); exp_wr.push_back({4'h7, 10'h101});
        exp_done.push_back(1'b0);
        request(1'b0, 7'h50, 4'd1);
        wait_done(300, n);
        @(negedge clk);
        chk("wr_ready_after_done", 32'(cmd_ready_o), 32'd1);
        chk("wr_all_words", 32'(exp_wr.size()), 32'd0);

        // Read 4 bytes from 0x50 with RX empty flag toggling
        rx_tog_en = 1'b1;
        rx_q.push_back(8'h11); rx_q.push_back(8'h22); rx_q.push_back(8'h33); rx_q.push_back(8'h44);
        exp_wr.push_back({4'h8, 10'h1A1}); exp_wr.push_back({4'h7, 10'h303});
        exp_rd.push_back(8'h11); exp_rd.push_back(8'h22); exp_rd.push_back(8'h33); exp_rd.push_back(8'h44);
        exp_done.push_back(1'b0);
        r0 = rdv_cnt;
        request(1'b1, 7'h50, 4'd3);
        wait_done(500, n);
        chk("rd_valid_count4", 32'(rdv_cnt - r0), 32'd4);
        chk("rd_all_bytes", 32'(exp_rd.size()), 32'd0);
        rx_tog_en = 1'b0;
        @(negedge clk);
        chk("rd_ready_after_done", 32'(cmd_ready_o), 32'd1);

        // TX FIFO full for 100 cycles during write data
        wr_src.push_back(8'h01); wr_src.push_back(8'h02); wr_src.push_back(8'h03);
        exp_wr.push_back({4'h8, 10'h142}); exp_wr.push_back({4'h8, 10'h001});
        exp_wr.push_back({4'h8, 10'h002}); exp_wr.push_back({4'h8, 10'h203});
        exp_wr.push_back({4'h7, 10'h102});
        exp_done.push_back(1'b0);
        d0 = wrr_cnt;
        request(1'b0, 7'h21, 4'd2);
        n = 0;
        while (wrr_cnt == d0 && n < 200) begin @(posedge clk); n++; end
        @(negedge clk);
        txfifo_f = 1'b1;
        prev = sb_stb_o;
        rises = 0;
        repeat (100) begin
            @(negedge clk);
            if (sb_stb_o && !prev) rises++;
            prev = sb_stb_o;
        end
        txfifo_f = 1'b0;
        chk("no_stb_while_full", 32'(rises), 32'd0);
        wait_done(300, n);
        chk("full_all_words", 32'(exp_wr.size()), 32'd0);

        // CMDR write never acked -> watchdog
        block_cmdr = 1'b1;
        wr_src.push_back(8'h77);
        exp_wr.push_back({4'h8, 10'h1A0}); exp_wr.push_back({4'h8, 10'h277});
        exp_done.push_back(1'b1);
        request(1'b0, 7'h50, 4'd0);
        n = 0;
        while (!(sb_stb_o && sb_adr_o == 4'h7) && n < 300) begin @(negedge clk); n++; end
        wait_done(5000, n);
        chk("timeout_latency", 32'((n >= TO_CYC) && (n <= TO_CYC + 3)), 32'd1);
        @(negedge clk);
        chk("to_ready_next", 32'(cmd_ready_o), 32'd1);
        chk("to_stb_low", 32'(sb_stb_o), 32'd0);
        block_cmdr = 1'b0;

        // Next request after timeout
        wr_src.push_back(8'h5A);
        exp_wr.push_back({4'h8, 10'h124}); exp_wr.push_back({4'h8, 10'h25A});
        exp_wr.push_back({4'h7, 10'h100});
        exp_done.push_back(1'b0);
        request(1'b0, 7'h12, 4'd0);
        wait_done(300, n);
        chk("post_to_all_words", 32'(exp_wr.size()), 32'd0);

        // Read len=3 ends early: master read complete with RX empty after 2 bytes
        rx_q.push_back(8'h5C); rx_q.push_back(8'h6D);
        mrdcmpl = 1'b1;
        exp_wr.push_back({4'h8, 10'h1A1}); exp_wr.push_back({4'h7, 10'h303});
        exp_rd.push_back(8'h5C); exp_rd.push_back(8'h6D);
        exp_done.push_back(1'b1);
        r0 = rdv_cnt;
        request(1'b1, 7'h50, 4'd3);
        wait_done(500, n);
        chk("mrdcmpl_rd_count2", 32'(rdv_cnt - r0), 32'd2);
        mrdcmpl = 1'b0;
        @(negedge clk);

        // Reset during RDATA, then a stray ack in IDLE
        block_rd = 1'b1;
        rx_q.push_back(8'h99);
        exp_wr.push_back({4'h8, 10'h1A1}); exp_wr.push_back({4'h7, 10'h300});
        request(1'b1, 7'h50, 4'd0);
        n = 0;
        while (!(sb_stb_o && !sb_we_o) && n < 300) begin @(negedge clk); n++; end
        chk("rdata_cycle_open", 32'(sb_stb_o && !sb_we_o), 32'd1);
        r0 = rdv_cnt; d0 = done_cnt;
        rst_i = 1'b1;
        @(negedge clk);
        chk("midrst_stb", 32'({sb_stb_o, sb_cs_o, sb_we_o}), 32'd0);
        chk("midrst_ready", 32'(cmd_ready_o), 32'd1);
        rst_i = 1'b0;
        stray_ack = 1'b1;
        @(negedge clk);
        stray_ack = 1'b0;
        repeat (5) @(negedge clk);
        chk("stray_no_rd_valid", 32'(rdv_cnt - r0), 32'd0);
        chk("stray_no_done", 32'(done_cnt - d0), 32'd0);
        chk("stray_stb_low", 32'(sb_stb_o), 32'd0);
        chk("stray_ready", 32'(cmd_ready_o), 32'd1);
        chk("stray_outputs", 32'({sb_adr_o, sb_dat_o, rd_data_o}), 32'd0);
        block_rd = 1'b0;
        rx_q.delete();

        chk("sb_wr_empty", 32'(exp_wr.size()), 32'd0);
        chk("sb_rd_empty", 32'(exp_rd.size()), 32'd0);
        chk("sb_done_empty", 32'(exp_done.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
